// File: rtl/axis_border_pad.sv
// axis_border_pad: puts a constant border of PAD pixels around every
// IN_WIDTH x IN_HEIGHT frame on an AXI4-Stream pixel link. The output frame
// is (IN_WIDTH+2*PAD) x (IN_HEIGHT+2*PAD). Output tuser marks end of line and
// tlast marks end of frame. Both are rebuilt from the column/row counters.
// Optional build macro AXIS_BORDER_PAD_FRAMECHK_EN adds the err_sticky output.
// err_sticky flags input tuser/tlast markers that disagree with the
// configured geometry. It never affects the datapath.
module axis_border_pad #(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int IN_WIDTH        = 510,
    parameter int IN_HEIGHT       = 510,
    parameter int PAD             = 1,
    parameter int PAD_VALUE       = 0,
    parameter int CNT_WIDTH       = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       frame_done,
    output logic                       busy
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
    ,
    output logic                       err_sticky
`endif
);

    localparam int OUT_W = IN_WIDTH + 2 * PAD;
    localparam int OUT_H = IN_HEIGHT + 2 * PAD;

    localparam logic [CNT_WIDTH-1:0] LAST_COL      = CNT_WIDTH'(OUT_W - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW      = CNT_WIDTH'(OUT_H - 1);
    localparam logic [CNT_WIDTH-1:0] PAD_LAST      = CNT_WIDTH'(PAD - 1);
    localparam logic [CNT_WIDTH-1:0] BODY_LAST_COL = CNT_WIDTH'(PAD + IN_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] BODY_LAST_ROW = CNT_WIDTH'(PAD + IN_HEIGHT - 1);
    localparam logic [AXIS_DATA_WIDTH-1:0] PAD_DATA = AXIS_DATA_WIDTH'(PAD_VALUE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOP    = 3'd1,
        LEFT   = 3'd2,
        BODY   = 3'd3,
        RIGHT  = 3'd4,
        BOTTOM = 3'd5
    } state_t;

    state_t                     state_reg;
    logic [CNT_WIDTH-1:0]       col_reg;
    logic [CNT_WIDTH-1:0]       row_reg;
    logic                       tvalid_reg;
    logic [AXIS_DATA_WIDTH-1:0] tdata_reg;
    logic                       tuser_reg;
    logic                       tlast_reg;

    logic slot_free;
    logic body_load;
    logic pad_load;
    logic do_load;
    logic at_eol;
    logic at_eof;

    // The counters always give the position of the next beat to load, so
    // end-of-line and end-of-frame come straight from the counters.
    assign slot_free = !tvalid_reg || m_axis_tready;
    assign body_load = (state_reg == BODY) && slot_free && s_axis_tvalid;
    // IDLE loads the first top-row pad beat as soon as enable is seen, so
    // a new frame starts one cycle after enable is sampled.
    assign pad_load  = slot_free && ((state_reg == TOP) || (state_reg == LEFT) ||
                                     (state_reg == RIGHT) || (state_reg == BOTTOM) ||
                                     ((state_reg == IDLE) && enable));
    assign do_load   = body_load || pad_load;
    assign at_eol    = (col_reg == LAST_COL);
    assign at_eof    = at_eol && (row_reg == LAST_ROW);

    assign s_axis_tready = (state_reg == BODY) && slot_free;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tuser  = tuser_reg;
    assign m_axis_tlast  = tlast_reg;
    assign frame_done    = tvalid_reg && m_axis_tready && tlast_reg;
    assign busy          = (state_reg != IDLE);

    // Region sequencer, position counters and output register slice; every load advances the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            row_reg    <= '0;
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tuser_reg  <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            if (slot_free) begin
                tvalid_reg <= do_load;
            end
            if (do_load) begin
                tdata_reg <= body_load ? s_axis_tdata : PAD_DATA;
                tuser_reg <= at_eol;
                tlast_reg <= at_eof;
                col_reg   <= at_eol ? '0 : col_reg + CNT_WIDTH'(1);
                if (at_eol) begin
                    row_reg <= at_eof ? '0 : row_reg + CNT_WIDTH'(1);
                end
                case (state_reg)
                    IDLE:    state_reg <= TOP;
                    TOP:     if (at_eol && (row_reg == PAD_LAST)) state_reg <= LEFT;
                    LEFT:    if (col_reg == PAD_LAST) state_reg <= BODY;
                    BODY:    if (col_reg == BODY_LAST_COL) state_reg <= RIGHT;
                    RIGHT:   if (at_eol) state_reg <= (row_reg == BODY_LAST_ROW) ? BOTTOM : LEFT;
                    BOTTOM:  if (at_eof) state_reg <= enable ? TOP : IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
    logic exp_tuser;
    logic exp_tlast;

    assign exp_tuser = (col_reg == BODY_LAST_COL);
    assign exp_tlast = exp_tuser && (row_reg == BODY_LAST_ROW);

    // Latch any accepted input beat whose end-of-line/end-of-frame markers disagree with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (body_load && ((s_axis_tuser != exp_tuser) || (s_axis_tlast != exp_tlast))) begin
            err_sticky <= 1'b1;
        end
    end
`else
    // Input markers are not needed when framing comes only from the counters.
    logic unused_framing;
    assign unused_framing = s_axis_tuser ^ s_axis_tlast;
`endif

endmodule

// File: tb/tb_axis_border_pad.sv
// Testbench for axis_border_pad with a small 4x3 frame and a 1-pixel border.
// Build with AXIS_BORDER_PAD_FRAMECHK_EN defined to also exercise err_sticky.
`timescale 1ns/1ps
module tb_axis_border_pad;

    localparam int W           = 8;
    localparam int IN_W        = 4;
    localparam int IN_H        = 3;
    localparam int PAD         = 1;
    localparam int PAD_VALUE   = 0;
    localparam int CNT_W       = 10;
    localparam int OUT_W       = IN_W + 2 * PAD;
    localparam int OUT_H       = IN_H + 2 * PAD;
    localparam int FRAME_BEATS = OUT_W * OUT_H;
    localparam int FRAME_PIX   = IN_W * IN_H;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [W-1:0] s_tdata = '0;
    logic         s_tuser = 1'b0;
    logic         s_tlast = 1'b0;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic [W-1:0] m_tdata;
    logic         m_tuser;
    logic         m_tlast;
    logic         frame_done;
    logic         busy;
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
    logic         err_sticky;
    bit           err_exp = 1'b0;
`endif

    always #5 clk = ~clk;

    axis_border_pad #(
        .AXIS_DATA_WIDTH(W),
        .IN_WIDTH(IN_W),
        .IN_HEIGHT(IN_H),
        .PAD(PAD),
        .PAD_VALUE(PAD_VALUE),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tuser(m_tuser),
        .m_axis_tlast(m_tlast),
        .frame_done(frame_done),
        .busy(busy)
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the padded frame is a geometric function of the input pixels.
    typedef struct packed {
        logic [W-1:0] data;
        logic         user;
        logic         last;
        logic         body;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] pix_q[$];

    task automatic add_frame(input bit seq);
        logic [W-1:0] px [FRAME_PIX];
        beat_t b;
        for (int i = 0; i < FRAME_PIX; i++) begin
            px[i] = seq ? W'(i + 1) : W'($urandom);
            pix_q.push_back(px[i]);
        end
        for (int r = 0; r < OUT_H; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                b.body = (r >= PAD) && (r < PAD + IN_H) && (c >= PAD) && (c < PAD + IN_W);
                if (b.body) b.data = px[(r - PAD) * IN_W + (c - PAD)];
                else        b.data = W'(PAD_VALUE);
                b.user = (c == OUT_W - 1);
                b.last = b.user && (r == OUT_H - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // rmode: 0 ready high, 1 toggle 1/0, 2 random. vmode: 0 always valid, 1 random, 2 three-cycle gap after pixel 6.
    // drop_at: enable falls once that many output beats are done. abort_at: reset after that many beats (-1 none).
    // bad_idx: input pixel index carrying an early end-of-line marker (-1 none).
    task automatic run(input int nframes, input bit seq, input int rmode, input int vmode,
                       input int drop_at, input int abort_at, input int bad_idx);
        int k = 0;
        int sent = 0;
        int cyc = 0;
        int gap = 0;
        int total;
        int npix;
        int j;
        bit in_hs = 1'b0;
        bit out_hs;
        bit exp_sr;
        bit prev_stall = 1'b0;
        logic [W+1:0] prev_out = '0;
        bit done = 1'b0;
        exp_q.delete();
        pix_q.delete();
        for (int f = 0; f < nframes; f++) add_frame(seq);
        total = nframes * FRAME_BEATS;
        npix = nframes * FRAME_PIX;
        while (!done) begin
            @(posedge clk);
            #1;
            enable = (k < drop_at);
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 2 == 0);
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (!(s_tvalid && !in_hs)) begin
                if (sent < npix) begin
                    case (vmode)
                        0: s_tvalid = 1'b1;
                        1: s_tvalid = ($urandom_range(0, 2) != 0);
                        default: begin
                            if (sent == 6 && gap < 3) begin
                                s_tvalid = 1'b0;
                                gap++;
                            end else begin
                                s_tvalid = 1'b1;
                            end
                        end
                    endcase
                    s_tdata = pix_q[sent];
                    s_tuser = ((sent % IN_W) == IN_W - 1);
                    if (bad_idx >= 0 && (sent == bad_idx || sent == bad_idx + 1)) s_tuser = !s_tuser;
                    s_tlast = ((sent % FRAME_PIX) == FRAME_PIX - 1);
                end else begin
                    s_tvalid = 1'b0;
                end
            end

            @(negedge clk);
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0;
                enable = 1'b0;
                s_tvalid = 1'b0;
                #1;
                chk("rst_tvalid", m_tvalid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_s_tready", s_tready, 0);
                chk("rst_frame_done", frame_done, 0);
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
                err_exp = 1'b0;
                chk("rst_err_sticky", err_sticky, 0);
`endif
                $display("run: reset asserted after %0d output beats", k);
                return;
            end
            out_hs = m_tvalid && m_tready;
            in_hs = s_tvalid && s_tready;
            if (cyc == 1) chk("start_valid", m_tvalid, 1);
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_fields", {m_tdata, m_tuser, m_tlast}, prev_out);
            end
            j = k + (m_tvalid ? 1 : 0);
            exp_sr = (!m_tvalid || m_tready) && (j < total) && exp_q[j].body;
            chk("s_tready", s_tready, exp_sr);
            if (out_hs) begin
                if (k < total) begin
                    chk("tdata", m_tdata, exp_q[k].data);
                    chk("tuser", m_tuser, exp_q[k].user);
                    chk("tlast", m_tlast, exp_q[k].last);
                    $display("beat %0d: data=%0d user=%0d last=%0d", k, m_tdata, m_tuser, m_tlast);
                end else begin
                    chk("extra_beat", 1, 0);
                end
            end
            chk("frame_done", frame_done, out_hs && (k < total) && exp_q[k].last);
            if (cyc > 0 && k < total - 1) chk("busy", busy, 1);
            if (vmode == 0 && rmode == 0 && cyc >= 1 && k < total) chk("no_gap", m_tvalid, 1);
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
            chk("err_sticky", err_sticky, err_exp);
            if (in_hs && bad_idx >= 0 && sent == bad_idx) err_exp = 1'b1;
`endif
            prev_stall = m_tvalid && !m_tready;
            prev_out = {m_tdata, m_tuser, m_tlast};
            if (in_hs) sent++;
            if (out_hs) k++;
            cyc++;
            if (k == total) done = 1'b1;
            if (cyc > 2000) begin
                chk("timeout", k, total);
                done = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        chk("end_tvalid", m_tvalid, 0);
        chk("end_busy", busy, 0);
        chk("end_s_tready", s_tready, 0);
        chk("in_count", sent, npix);
        $display("run: %0d frames, %0d beats out, %0d pixels in, %0d cycles", nframes, k, sent, cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_tdata", m_tdata, 0);
        chk("reset_tuser", m_tuser, 0);
        chk("reset_tlast", m_tlast, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_s_tready", s_tready, 0);
`ifdef AXIS_BORDER_PAD_FRAMECHK_EN
        chk("reset_err_sticky", err_sticky, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_tvalid", m_tvalid, 0);

        run(1, 1'b1, 0, 0, 1, -1, -1);     // basic frame, pixels 1..12
        run(1, 1'b1, 1, 0, 1, -1, -1);     // ready toggling 1,0
        run(1, 1'b1, 0, 2, 1, -1, -1);     // input bubble after pixel 6
        run(2, 1'b0, 0, 0, 40, -1, -1);    // back-to-back, enable drops in 2nd body
        run(1, 1'b0, 2, 1, 1, -1, 2);      // early end-of-line on pixel 3
        run(1, 1'b0, 2, 1, 1, 10, -1);     // reset after 10 output beats
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1, 1'b1, 0, 0, 1, -1, -1);     // fresh frame after reset
        run(3, 1'b0, 2, 1, 80, -1, -1);    // random traffic over three frames

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_border_pad.md
Name: axis_border_pad

Overview:
- Downstream of the image filter top; consumes its AXI4-Stream pixel output, where each frame is shrunk by the 3x3 kernel border.
- Restores full frame geometry by emitting a constant-valued border of PAD pixels around each IN_WIDTH x IN_HEIGHT input frame.
- Output frame is (IN_WIDTH+2*PAD) x (IN_HEIGHT+2*PAD) with regenerated tuser (end of line) and tlast (end of frame).
- Replaces software dummy-line insertion ahead of the BMP writer.

Parameters:
- AXIS_DATA_WIDTH, 8, pixel width.
- IN_WIDTH, 510, input pixels per line.
- IN_HEIGHT, 510, input lines per frame.
- PAD, 1, border width in pixels on each side (1..7).
- PAD_VALUE, 0, constant border pixel value.
- CNT_WIDTH, 10, column/row counter width; must hold IN_WIDTH+2*PAD-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- enable  in  1  level; frames are produced while high
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  AXIS_DATA_WIDTH  input pixel
- s_axis_tuser  in  1  input end of line
- s_axis_tlast  in  1  input end of frame
- m_axis_tvalid  out  1  output pixel valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  AXIS_DATA_WIDTH  output pixel
- m_axis_tuser  out  1  output end of line
- m_axis_tlast  out  1  output end of frame
- frame_done  out  1  one-cycle pulse on the output tlast handshake
- busy  out  1  high when state is not IDLE

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0.
- Output stage is one register slice. It loads when slot_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = (state==BODY) && slot_free. Input is never accepted outside BODY.
- Throughput is 1 beat/cycle with m_axis_tready held high. An input pixel accepted at edge N is on m_axis_tdata after edge N.
- Counters: col 0..OUT_W-1 and row 0..OUT_H-1, where OUT_W=IN_WIDTH+2*PAD and OUT_H=IN_HEIGHT+2*PAD. They advance on every output-register load.
- m_axis_tuser=1 when col==OUT_W-1.
- m_axis_tlast=1 when col==OUT_W-1 && row==OUT_H-1.
- State machine:
  - IDLE: when enable=1, go to TOP. The first pad beat is valid the cycle after enable is sampled high.
  - TOP: emit PAD_VALUE for PAD full rows, then go to LEFT.
  - LEFT: emit PAD beats of PAD_VALUE, then go to BODY.
  - BODY: forward exactly IN_WIDTH input beats. tdata passes through; input tuser/tlast are not forwarded. Then go to RIGHT.
  - RIGHT: emit PAD beats of PAD_VALUE. Go to LEFT if fewer than IN_HEIGHT body rows are done, else to BOTTOM.
  - BOTTOM: emit PAD rows of PAD_VALUE. On the tlast load, go to TOP if enable=1, else IDLE.
- If s_axis_tvalid=0 in BODY, the output bubbles and the counters hold.
- If m_axis_tready=0 while m_axis_tvalid=1, all output fields hold stable and s_axis_tready=0.
- enable falling mid-frame: the current frame completes; the block then enters IDLE.
- Reset mid-frame: immediate return to IDLE. A partial frame is discarded and is not resumed.
- Framing is counter-based only. Input tuser/tlast are ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: AXIS_BORDER_PAD_FRAMECHK_EN.
- With the macro:
  - Adds output err_sticky (1 bit, reset 0).
  - err_sticky sets on any accepted input beat where s_axis_tuser != (body col==IN_WIDTH-1).
  - err_sticky also sets where s_axis_tlast != (last body pixel of frame).
  - err_sticky clears only on reset. Datapath behaviour is unchanged.
- Without the macro: no err_sticky port, and input tuser/tlast are unused.

Test Plan:
- Basic frame: IN_WIDTH=4, IN_HEIGHT=3, PAD=1, PAD_VALUE=0, inputs 1..12, m_axis_tready=1.
  - Required: 30 beats, rows 0,0,0,0,0,0 / 0,1,2,3,4,0 / 0,5,6,7,8,0 / 0,9,10,11,12,0 / 0,0,0,0,0,0.
  - tuser on beats 5,11,17,23,29 (0-based); tlast and frame_done only on beat 29.
- Backpressure: same frame, m_axis_tready toggling 1,0 every cycle.
  - Required: identical 30-beat sequence, output fields stable while stalled, no input accepted during a stall.
- Input bubbles: s_axis_tvalid low 3 cycles between pixels 6 and 7.
  - Required: output sequence unchanged, counters hold, busy=1 throughout.
- Back-to-back frames, then enable drop: enable high for two frames, dropped during the second frame's body.
  - Required: 60 beats with no gap between frames, then IDLE, busy=0.
- Reset mid-frame: rst_n low after output beat 10.
  - Required: m_axis_tvalid=0 immediately; after release with enable=1, the next frame starts at row 0, col 0.
- With AXIS_BORDER_PAD_FRAMECHK_EN: assert s_axis_tuser on input pixel 3 instead of 4.
  - Required: err_sticky=1 the cycle after that beat, held until reset, with pixel data unchanged.
